// File: rtl/billiard_pkg.sv
// Shared constants for the billiard game: collision type indices and default widths.
package billiard_pkg;
   localparam int NUM_COLL    = 5;
   localparam int COLL_WR     = 0;
   localparam int COLL_WB     = 1;
   localparam int COLL_RB     = 2;
   localparam int COLL_WH     = 3;
   localparam int COLL_RH     = 4;
   localparam int DEF_COORD_W = 11;
   localparam int DEF_HOLE_W  = 3;
endpackage

// File: rtl/collision_one_shot.sv
// Once-per-frame pulse generator for a single collision type, with a per-frame summary flag.
module collision_one_shot (
   input  logic clk,
   input  logic resetN,
   input  logic startOfFrame,
   input  logic hit,
   output logic pulse,
   output logic flag,
   output logic frameFlag
);

   // The startOfFrame cycle opens a new frame, so a hit there pulses regardless of the old flag.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pulse     <= 1'b0;
         flag      <= 1'b0;
         frameFlag <= 1'b0;
      end else begin
         pulse <= hit & (startOfFrame | ~flag);
         if (startOfFrame) begin
            frameFlag <= flag | hit;
            flag      <= hit;
         end else begin
            flag <= flag | hit;
         end
      end
   end

endmodule

// File: rtl/collision_detector.sv
// Detects ball/border/hole overlaps in the pixel stream; reports pocketing and first white/red contact.
module collision_detector
   import billiard_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int HOLE_W  = DEF_HOLE_W
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                startOfFrame,
   input  logic [COORD_W-1:0]  pixelX,
   input  logic [COORD_W-1:0]  pixelY,
   input  logic                whiteBallDR,
   input  logic                redBallDR,
   input  logic                bordersDR,
   input  logic                holesDR,
   input  logic [HOLE_W-1:0]   holeIndex,
   input  logic [HOLE_W-1:0]   targetHole,
   output logic [NUM_COLL-1:0] collisionPulse,
   output logic [NUM_COLL-1:0] frameCollisions,
   output logic                redPocketed,
   output logic [HOLE_W-1:0]   redPocketHole,
   output logic                pocketCorrect,
   output logic                contactValid,
   output logic [COORD_W-1:0]  contactX,
   output logic [COORD_W-1:0]  contactY
);

   logic [NUM_COLL-1:0] hit;
   logic [NUM_COLL-1:0] flag;
   logic                wr_fire;
   logic                rh_fire;

   assign hit[COLL_WR] = whiteBallDR & redBallDR;
   assign hit[COLL_WB] = whiteBallDR & bordersDR;
   assign hit[COLL_RB] = redBallDR   & bordersDR;
   assign hit[COLL_WH] = whiteBallDR & holesDR;
   assign hit[COLL_RH] = redBallDR   & holesDR;

   for (genvar i = 0; i < NUM_COLL; i++) begin : g_shot
      collision_one_shot u_shot (
         .clk          (clk),
         .resetN       (resetN),
         .startOfFrame (startOfFrame),
         .hit          (hit[i]),
         .pulse        (collisionPulse[i]),
         .flag         (flag[i]),
         .frameFlag    (frameCollisions[i])
      );
   end

   // Same condition the one-shots use to pulse, so capture lines up with the pulse cycle.
   assign wr_fire = hit[COLL_WR] & (startOfFrame | ~flag[COLL_WR]);
   assign rh_fire = hit[COLL_RH] & (startOfFrame | ~flag[COLL_RH]);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         redPocketed   <= 1'b0;
         redPocketHole <= '0;
         pocketCorrect <= 1'b0;
      end else begin
         redPocketed <= rh_fire;
         if (rh_fire) begin
            redPocketHole <= holeIndex;
            pocketCorrect <= (holeIndex == targetHole);
         end
      end
   end

   // Contact point: first WR pixel of the frame; validity expires at frame start.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         contactValid <= 1'b0;
         contactX     <= '0;
         contactY     <= '0;
      end else if (wr_fire) begin
         contactValid <= 1'b1;
         contactX     <= pixelX;
         contactY     <= pixelY;
      end else if (startOfFrame) begin
         contactValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_collision_detector.sv
// Table-driven bench for collision_detector with an expected-output queue.
module tb_collision_detector;
   localparam int CW = 11;
   localparam int HW = 3;

   typedef struct packed {
      logic [4:0]    p;
      logic [4:0]    fc;
      logic          pk;
      logic [HW-1:0] ph;
      logic          pc;
      logic          cv;
      logic [CW-1:0] cx;
      logic [CW-1:0] cy;
   } out_t;

   typedef struct packed {
      logic          sof;
      logic          w;
      logic          r;
      logic          b;
      logic          h;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [HW-1:0] hi;
      logic [HW-1:0] tg;
      out_t          exp;
   } vec_t;

   logic          clk;
   logic          resetN;
   logic          startOfFrame;
   logic [CW-1:0] pixelX;
   logic [CW-1:0] pixelY;
   logic          whiteBallDR;
   logic          redBallDR;
   logic          bordersDR;
   logic          holesDR;
   logic [HW-1:0] holeIndex;
   logic [HW-1:0] targetHole;
   logic [4:0]    collisionPulse;
   logic [4:0]    frameCollisions;
   logic          redPocketed;
   logic [HW-1:0] redPocketHole;
   logic          pocketCorrect;
   logic          contactValid;
   logic [CW-1:0] contactX;
   logic [CW-1:0] contactY;

   int   total;
   int   bad;
   vec_t tbl[$];
   out_t sb[$];

   collision_detector #(.COORD_W(CW), .HOLE_W(HW)) dut (
      .clk             (clk),
      .resetN          (resetN),
      .startOfFrame    (startOfFrame),
      .pixelX          (pixelX),
      .pixelY          (pixelY),
      .whiteBallDR     (whiteBallDR),
      .redBallDR       (redBallDR),
      .bordersDR       (bordersDR),
      .holesDR         (holesDR),
      .holeIndex       (holeIndex),
      .targetHole      (targetHole),
      .collisionPulse  (collisionPulse),
      .frameCollisions (frameCollisions),
      .redPocketed     (redPocketed),
      .redPocketHole   (redPocketHole),
      .pocketCorrect   (pocketCorrect),
      .contactValid    (contactValid),
      .contactX        (contactX),
      .contactY        (contactY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic sof, input logic w, input logic r, input logic b,
                               input logic h, input int x, input int y, input int hi,
                               input logic [4:0] p, input logic [4:0] fc, input logic pk,
                               input int ph, input logic pc, input logic cv,
                               input int cx, input int cy);
      vec_t v;
      v.sof    = sof;  v.w = w;  v.r = r;  v.b = b;  v.h = h;
      v.x      = CW'(x);
      v.y      = CW'(y);
      v.hi     = HW'(hi);
      v.tg     = HW'(3);
      v.exp.p  = p;
      v.exp.fc = fc;
      v.exp.pk = pk;
      v.exp.ph = HW'(ph);
      v.exp.pc = pc;
      v.exp.cv = cv;
      v.exp.cx = CW'(cx);
      v.exp.cy = CW'(cy);
      return v;
   endfunction

   function automatic out_t actual();
      out_t o;
      o.p  = collisionPulse;
      o.fc = frameCollisions;
      o.pk = redPocketed;
      o.ph = redPocketHole;
      o.pc = pocketCorrect;
      o.cv = contactValid;
      o.cx = contactX;
      o.cy = contactY;
      return o;
   endfunction

   task automatic check(input string name, input out_t want);
      out_t got;
      got = actual();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got p=%b fc=%b pk=%b ph=%0d pc=%b cv=%b cx=%0d cy=%0d, want p=%b fc=%b pk=%b ph=%0d pc=%b cv=%b cx=%0d cy=%0d",
                  name, got.p, got.fc, got.pk, got.ph, got.pc, got.cv, got.cx, got.cy,
                  want.p, want.fc, want.pk, want.ph, want.pc, want.cv, want.cx, want.cy);
      end
   endtask

   task automatic idle_inputs();
      startOfFrame = 1'b0;
      whiteBallDR  = 1'b0;
      redBallDR    = 1'b0;
      bordersDR    = 1'b0;
      holesDR      = 1'b0;
      pixelX       = '0;
      pixelY       = '0;
      holeIndex    = '0;
      targetHole   = HW'(3);
   endtask

   task automatic apply(input vec_t v, input string name);
      out_t want;
      @(negedge clk);
      startOfFrame = v.sof;
      whiteBallDR  = v.w;
      redBallDR    = v.r;
      bordersDR    = v.b;
      holesDR      = v.h;
      pixelX       = v.x;
      pixelY       = v.y;
      holeIndex    = v.hi;
      targetHole   = v.tg;
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: scoreboard empty, got 0 entries want 1", name);
      end else begin
         want = sb.pop_front();
         check(name, want);
      end
   endtask

   initial begin
      vec_t v;
      total = 0;
      bad   = 0;
      idle_inputs();
      resetN = 1'b0;

      // Frame A: WB hit, 10-cycle WR overlap, correct pocket in hole 3
      tbl.push_back(mk(1,0,0,0,0,   0, 0,0, 5'b00000,5'b00000,0,0,0,0,  0, 0));
      tbl.push_back(mk(0,1,0,1,0, 100,50,0, 5'b00010,5'b00000,0,0,0,0,  0, 0));
      tbl.push_back(mk(0,1,0,1,0, 101,50,0, 5'b00000,5'b00000,0,0,0,0,  0, 0));
      tbl.push_back(mk(0,0,0,0,0,   0, 0,0, 5'b00000,5'b00000,0,0,0,0,  0, 0));
      for (int i = 0; i < 10; i++)
         tbl.push_back(mk(0,1,1,0,0, 200+i,60,0, (i == 0) ? 5'b00001 : 5'b00000,
                          5'b00000,0,0,0,1,200,60));
      tbl.push_back(mk(0,0,1,0,1,   0, 0,3, 5'b10000,5'b00000,1,3,1,1,200,60));
      tbl.push_back(mk(0,0,1,0,1,   0, 0,3, 5'b00000,5'b00000,0,3,1,1,200,60));
      // Frame B: wrong pocket (hole 5), then WR contact
      tbl.push_back(mk(1,0,0,0,0,   0, 0,0, 5'b00000,5'b10011,0,3,1,0,200,60));
      tbl.push_back(mk(0,0,1,0,1,   0, 0,5, 5'b10000,5'b10011,1,5,0,0,200,60));
      tbl.push_back(mk(0,0,0,0,0,   0, 0,0, 5'b00000,5'b10011,0,5,0,0,200,60));
      tbl.push_back(mk(0,1,1,0,0, 300,70,0, 5'b00001,5'b10011,0,5,0,1,300,70));
      // Frame C: WR on the startOfFrame cycle itself
      tbl.push_back(mk(1,1,1,0,0,   5, 6,0, 5'b00001,5'b10001,0,5,0,1,  5, 6));
      tbl.push_back(mk(0,0,0,0,0,   0, 0,0, 5'b00000,5'b10001,0,5,0,1,  5, 6));
      // Frame D: every DR high at once
      tbl.push_back(mk(1,0,0,0,0,   0, 0,0, 5'b00000,5'b00001,0,5,0,0,  5, 6));
      tbl.push_back(mk(0,1,1,1,1,   7, 8,3, 5'b11111,5'b00001,1,3,1,1,  7, 8));
      tbl.push_back(mk(0,1,1,1,1,   7, 8,3, 5'b00000,5'b00001,0,3,1,1,  7, 8));
      // Frames E..G: summary of a WB-only frame, then of an empty frame
      tbl.push_back(mk(1,0,0,0,0,   0, 0,0, 5'b00000,5'b11111,0,3,1,0,  7, 8));
      tbl.push_back(mk(0,1,0,1,0,   1, 1,0, 5'b00010,5'b11111,0,3,1,0,  7, 8));
      tbl.push_back(mk(1,0,0,0,0,   0, 0,0, 5'b00000,5'b00010,0,3,1,0,  7, 8));
      tbl.push_back(mk(0,0,0,0,0,   0, 0,0, 5'b00000,5'b00010,0,3,1,0,  7, 8));
      tbl.push_back(mk(1,0,0,0,0,   0, 0,0, 5'b00000,5'b00000,0,3,1,0,  7, 8));
      tbl.push_back(mk(0,1,1,0,0,   9, 9,0, 5'b00001,5'b00000,0,3,1,1,  9, 9));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", '0);
      @(negedge clk);
      resetN = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // Mid-frame asynchronous reset after flags are set
      @(negedge clk);
      idle_inputs();
      resetN = 1'b0;
      #1;
      check("midframe_reset", '0);
      #1;
      resetN = 1'b1;

      // WR again without startOfFrame must pulse immediately
      v = mk(0,1,1,0,0, 11,12,0, 5'b00001,5'b00000,0,0,0,1,11,12);
      apply(v, "after_reset_wr");
      v = mk(0,0,1,0,1,  0, 0,2, 5'b10000,5'b00000,1,2,0,1,11,12);
      apply(v, "after_reset_rh");
      v = mk(0,1,1,0,0, 13,14,0, 5'b00000,5'b00000,0,2,0,1,11,12);
      apply(v, "after_reset_wr_again");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion, want finish before 100000");
      $fatal(1);
   end

endmodule
